// File: rtl/addressable_latch_8_seq.sv
// Serial/direct writer into an 8-line latch bank; optional parity beat via ADDRESSABLE_LATCH_8_SEQ_PARITY_EN.
// Latency: latch_out/demux_out change one cycle after the accepting edge; frame_done/err pulse the cycle after.
// Backpressure: in_ready is high only while a frame is open; in_valid low stalls the frame indefinitely.
module addressable_latch_8_seq #(
  parameter int MSB_FIRST = 0,
  parameter int FRAME_LEN = 8
) (
  input  logic       sysclk,
  input  logic       sys_rst,
  input  logic       clr,
  input  logic       wr,
  input  logic [2:0] wr_addr,
  input  logic       wr_bit,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic [7:0] latch_out,
  output logic [7:0] demux_out,
  output logic [2:0] cur_addr,
  output logic       busy,
  output logic       frame_done,
  output logic       err,
  output logic       parity_err
);

  if (FRAME_LEN < 1 || FRAME_LEN > 8) begin : gFrameLenCheck
    $error("addressable_latch_8_seq: FRAME_LEN must be in 1..8");
  end

  localparam logic [2:0] START_ADDR = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
  // stepping by 7 is a 3-bit decrement
  localparam logic [2:0] ADDR_STEP  = (MSB_FIRST != 0) ? 3'd7 : 3'd1;
  localparam logic [3:0] LAST_CNT   = 4'(FRAME_LEN - 1);

`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t     stateQ;
  state_t     stateD;
  logic [3:0] bitCnt;
  logic       isIdle;
  logic       dataAccept;
  logic       lastBit;
  logic       frameEnd;
  logic       wrEn;
  logic [2:0] wrIdx;
  logic       wrVal;

  assign isIdle     = (stateQ == IDLE);
  assign dataAccept = in_valid && in_ready && (stateQ == SHIFT);
  assign lastBit    = dataAccept && (bitCnt == LAST_CNT);

`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
  logic parAcc;
  logic parAccept;

  assign parAccept = in_valid && in_ready && (stateQ == PAR);
  assign frameEnd  = parAccept;
`else
  assign frameEnd  = lastBit;
`endif

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (start) stateD = SHIFT;
`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
      SHIFT:   if (lastBit) stateD = PAR;
      PAR:     if (parAccept) stateD = IDLE;
`else
      SHIFT:   if (lastBit) stateD = IDLE;
`endif
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (stateQ != IDLE) begin
      in_ready = 1'b1;
      busy     = 1'b1;
    end
  end

  // A serial bit outranks a direct write; start in IDLE swallows a coincident wr.
  always_comb begin
    wrEn  = 1'b0;
    wrIdx = wr_addr;
    wrVal = wr_bit;
    if (dataAccept) begin
      wrEn  = 1'b1;
      wrIdx = cur_addr;
      wrVal = in_bit;
    end else if (isIdle && wr && !start) begin
      wrEn  = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      latch_out <= 8'h00;
      demux_out <= 8'h00;
    end else if (clr) begin
      latch_out <= 8'h00;
      demux_out <= 8'h00;
    end else begin
      demux_out <= 8'h00;
      if (wrEn) begin
        latch_out[wrIdx] <= wrVal;
        demux_out[wrIdx] <= wrVal;
      end
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      cur_addr <= START_ADDR;
      bitCnt   <= 4'd0;
    end else if (isIdle && start) begin
      cur_addr <= START_ADDR;
      bitCnt   <= 4'd0;
    end else if (lastBit) begin
      cur_addr <= START_ADDR;
      bitCnt   <= 4'd0;
    end else if (dataAccept) begin
      cur_addr <= cur_addr + ADDR_STEP;
      bitCnt   <= bitCnt + 4'd1;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= frameEnd;
      err        <= isIdle ? (start && wr) : (start || wr);
    end
  end

`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
  // parAcc is the XOR of data bits so far; a correct odd-parity bit is its complement
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      parAcc     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= parAccept && (in_bit == parAcc);
      if (isIdle && start) begin
        parAcc <= 1'b0;
      end else if (dataAccept) begin
        parAcc <= parAcc ^ in_bit;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_addressable_latch_8_seq.sv
// Bench for addressable_latch_8_seq: two configurations (LSB-first/8 bits and MSB-first/4 bits)
// checked every cycle against a frame-position model plus hand-computed directed expectations.
module tb_addressable_latch_8_seq;

`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       clr;
    logic       wr;
    logic [2:0] wrAddr;
    logic       wrBit;
    logic       start;
    logic       inValid;
    logic       inBit;
  } stim_t;

  typedef struct packed {
    logic [7:0] latch;
    logic [7:0] demux;
    logic [1:0] phase;   // 0 idle, 1 data bits, 2 waiting for parity
    logic [3:0] pos;     // index of the next data bit within the frame
    logic [3:0] ones;    // number of 1s received this frame
    logic       done;
    logic       err;
    logic       perr;
  } model_t;

  logic       clk;
  logic       rst;
  logic       cmpOn;
  stim_t      st[2];
  model_t     m[2];
  int         vecCnt;
  int         missCnt;

  logic [7:0] latchOut[2];
  logic [7:0] demuxOut[2];
  logic [2:0] curAddr[2];
  logic       inReady[2];
  logic       busy[2];
  logic       frameDone[2];
  logic       err[2];
  logic       parityErr[2];

  addressable_latch_8_seq #(.MSB_FIRST(0), .FRAME_LEN(8)) u0 (
    .sysclk(clk), .sys_rst(rst), .clr(st[0].clr), .wr(st[0].wr), .wr_addr(st[0].wrAddr),
    .wr_bit(st[0].wrBit), .start(st[0].start), .in_valid(st[0].inValid), .in_bit(st[0].inBit),
    .in_ready(inReady[0]), .latch_out(latchOut[0]), .demux_out(demuxOut[0]), .cur_addr(curAddr[0]),
    .busy(busy[0]), .frame_done(frameDone[0]), .err(err[0]), .parity_err(parityErr[0])
  );

  addressable_latch_8_seq #(.MSB_FIRST(1), .FRAME_LEN(4)) u1 (
    .sysclk(clk), .sys_rst(rst), .clr(st[1].clr), .wr(st[1].wr), .wr_addr(st[1].wrAddr),
    .wr_bit(st[1].wrBit), .start(st[1].start), .in_valid(st[1].inValid), .in_bit(st[1].inBit),
    .in_ready(inReady[1]), .latch_out(latchOut[1]), .demux_out(demuxOut[1]), .cur_addr(curAddr[1]),
    .busy(busy[1]), .frame_done(frameDone[1]), .err(err[1]), .parity_err(parityErr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] addrOf(input int d, input logic [3:0] pos);
    if (d == 1) return 3'(7 - int'(pos));
    return 3'(pos);
  endfunction

  function automatic model_t stepModel(input model_t cur, input stim_t s, input int d);
    model_t     n;
    int         len;
    logic [2:0] a;
    n     = cur;
    len   = (d == 0) ? 8 : 4;
    n.demux = 8'h00;
    n.done  = 1'b0;
    n.err   = 1'b0;
    n.perr  = 1'b0;
    if (cur.phase == 2'd0) begin
      if (s.start) begin
        n.phase = 2'd1;
        n.pos   = 4'd0;
        n.ones  = 4'd0;
        n.err   = s.wr;
      end else if (s.wr) begin
        n.latch[s.wrAddr] = s.wrBit;
        n.demux[s.wrAddr] = s.wrBit;
      end
    end else begin
      n.err = s.start | s.wr;
      if (s.inValid) begin
        if (cur.phase == 2'd1) begin
          a = addrOf(d, cur.pos);
          n.latch[a] = s.inBit;
          n.demux[a] = s.inBit;
          n.ones     = cur.ones + 4'(s.inBit);
          n.pos      = cur.pos + 4'd1;
          if (int'(n.pos) == len) begin
            n.pos   = 4'd0;
            n.phase = PAR_EN ? 2'd2 : 2'd0;
            n.done  = !PAR_EN;
          end
        end else begin
          n.phase = 2'd0;
          n.done  = 1'b1;
          n.perr  = ((int'(cur.ones) + int'(s.inBit)) % 2) == 0;
        end
      end
    end
    if (s.clr) begin
      n.latch = 8'h00;
      n.demux = 8'h00;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) m[d] <= '0;
      else     m[d] <= stepModel(m[d], st[d], d);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmpOn) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("u%0d.latch_out", d), latchOut[d], m[d].latch);
        chk($sformatf("u%0d.demux_out", d), demuxOut[d], m[d].demux);
        chk($sformatf("u%0d.cur_addr", d), 8'(curAddr[d]), 8'(addrOf(d, m[d].pos)));
        chk($sformatf("u%0d.in_ready", d), 8'(inReady[d]), 8'(m[d].phase != 2'd0));
        chk($sformatf("u%0d.busy", d), 8'(busy[d]), 8'(m[d].phase != 2'd0));
        chk($sformatf("u%0d.frame_done", d), 8'(frameDone[d]), 8'(m[d].done));
        chk($sformatf("u%0d.err", d), 8'(err[d]), 8'(m[d].err));
        chk($sformatf("u%0d.parity_err", d), 8'(parityErr[d]), 8'(m[d].perr));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sendBit(input int d, input logic b);
    st[d].inValid = 1'b1;
    st[d].inBit   = b;
    cyc(1);
    st[d].inValid = 1'b0;
    st[d].inBit   = 1'b0;
  endtask

  task automatic startFrame(input int d);
    st[d].start = 1'b1;
    cyc(1);
    st[d].start = 1'b0;
  endtask

  task automatic finishFrame(input int d, input logic p);
    if (PAR_EN) sendBit(d, p);
  endtask

  task automatic directWrite(input int d, input logic [2:0] a, input logic b, input logic c);
    st[d].wr     = 1'b1;
    st[d].wrAddr = a;
    st[d].wrBit  = b;
    st[d].clr    = c;
    cyc(1);
    st[d].wr     = 1'b0;
    st[d].clr    = 1'b0;
  endtask

  initial begin
    vecCnt  = 0;
    missCnt = 0;
    cmpOn   = 1'b0;
    st[0]   = '0;
    st[1]   = '0;
    rst     = 1'b1;
    #12;
    chk("rst.latch0", latchOut[0], 8'h00);
    chk("rst.cur_addr0", 8'(curAddr[0]), 8'h00);
    chk("rst.cur_addr1", 8'(curAddr[1]), 8'h07);
    chk("rst.in_ready1", 8'(inReady[1]), 8'h00);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    cmpOn = 1'b1;

    // reset in the middle of a frame
    startFrame(0);
    sendBit(0, 1'b1);
    sendBit(0, 1'b1);
    sendBit(0, 1'b1);
    chk("midframe.latch", latchOut[0], 8'h07);
    rst = 1'b1;
    #1;
    chk("midrst.latch", latchOut[0], 8'h00);
    chk("midrst.in_ready", 8'(inReady[0]), 8'h00);
    chk("midrst.busy", 8'(busy[0]), 8'h00);
    chk("midrst.frame_done", 8'(frameDone[0]), 8'h00);
    cyc(1);
    rst = 1'b0;

    // direct write
    directWrite(0, 3'd5, 1'b1, 1'b0);
    chk("wr.latch", latchOut[0], 8'h20);
    chk("wr.demux", demuxOut[0], 8'h20);
    cyc(1);
    chk("wr.demux_clear", demuxOut[0], 8'h00);

    // LSB-first frame with a stall after bit 3
    startFrame(0);
    chk("c.cur_addr", 8'(curAddr[0]), 8'h00);
    chk("c.in_ready", 8'(inReady[0]), 8'h01);
    sendBit(0, 1'b1);
    sendBit(0, 1'b0);
    sendBit(0, 1'b1);
    cyc(2);
    sendBit(0, 1'b1);
    sendBit(0, 1'b0);
    sendBit(0, 1'b0);
    sendBit(0, 1'b1);
    chk("c.done_early", 8'(frameDone[0]), 8'h00);
    sendBit(0, 1'b0);
    finishFrame(0, 1'b1);
    chk("c.latch", latchOut[0], 8'h4D);
    chk("c.frame_done", 8'(frameDone[0]), 8'h01);
    chk("c.busy", 8'(busy[0]), 8'h00);
    cyc(1);
    chk("c.done_pulse", 8'(frameDone[0]), 8'h00);

    // MSB-first 4-bit frame
    startFrame(1);
    chk("d.cur_addr_start", 8'(curAddr[1]), 8'h07);
    sendBit(1, 1'b1);
    sendBit(1, 1'b1);
    sendBit(1, 1'b0);
    chk("d.cur_addr_mid", 8'(curAddr[1]), 8'h04);
    sendBit(1, 1'b1);
    finishFrame(1, 1'b0);
    chk("d.latch", latchOut[1], 8'hD0);
    chk("d.cur_addr_end", 8'(curAddr[1]), 8'h07);
    chk("d.frame_done", 8'(frameDone[1]), 8'h01);

    // conflicts while busy, clr colliding with the 3rd bit
    startFrame(0);
    sendBit(0, 1'b1);
    st[0].start = 1'b1;
    cyc(1);
    st[0].start = 1'b0;
    chk("e.err_start", 8'(err[0]), 8'h01);
    chk("e.busy", 8'(busy[0]), 8'h01);
    directWrite(0, 3'd2, 1'b0, 1'b0);
    chk("e.err_wr", 8'(err[0]), 8'h01);
    sendBit(0, 1'b1);
    chk("e.latch_pre_clr", latchOut[0], 8'h4F);
    st[0].clr = 1'b1;
    sendBit(0, 1'b1);
    st[0].clr = 1'b0;
    chk("e.latch_clr", latchOut[0], 8'h00);
    chk("e.cur_addr", 8'(curAddr[0]), 8'h03);
    repeat (5) sendBit(0, 1'b1);
    finishFrame(0, 1'b1);
    chk("e.latch", latchOut[0], 8'hF8);
    chk("e.frame_done", 8'(frameDone[0]), 8'h01);

    // start and wr together in IDLE: wr dropped
    st[1].start  = 1'b1;
    st[1].wr     = 1'b1;
    st[1].wrAddr = 3'd0;
    st[1].wrBit  = 1'b1;
    cyc(1);
    st[1].start  = 1'b0;
    st[1].wr     = 1'b0;
    chk("f.err", 8'(err[1]), 8'h01);
    chk("f.busy", 8'(busy[1]), 8'h01);
    chk("f.latch", latchOut[1], 8'hD0);
    repeat (4) sendBit(1, 1'b0);
    finishFrame(1, 1'b1);
    chk("f.latch_end", latchOut[1], 8'h00);
    chk("f.frame_done", 8'(frameDone[1]), 8'h01);

    // clr beats a direct write in IDLE
    directWrite(0, 3'd0, 1'b1, 1'b1);
    chk("g.latch", latchOut[0], 8'h00);
    chk("g.demux", demuxOut[0], 8'h00);
    directWrite(0, 3'd3, 1'b1, 1'b0);
    chk("g.latch2", latchOut[0], 8'h08);
    chk("g.demux2", demuxOut[0], 8'h08);

    // all-ones frame, then parity handling
    startFrame(0);
    repeat (8) sendBit(0, 1'b1);
`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
    chk("h.wait_par_done", 8'(frameDone[0]), 8'h00);
    chk("h.wait_par_ready", 8'(inReady[0]), 8'h01);
    sendBit(0, 1'b1);
`endif
    chk("h.latch", latchOut[0], 8'hFF);
    chk("h.frame_done", 8'(frameDone[0]), 8'h01);
    chk("h.parity_ok", 8'(parityErr[0]), 8'h00);
`ifdef ADDRESSABLE_LATCH_8_SEQ_PARITY_EN
    startFrame(0);
    repeat (8) sendBit(0, 1'b1);
    sendBit(0, 1'b0);
    chk("h.bad_par_done", 8'(frameDone[0]), 8'h01);
    chk("h.bad_par_err", 8'(parityErr[0]), 8'h01);
`endif

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
